// File: rtl/approx_mult_err_monitor.sv
// Windowed error-statistics monitor for W x W approximate multipliers (exact product recomputed).
// Define ERR_MON_SQ_EN to add the saturating sum-of-squared-error output sum_sq_err.
module approx_mult_err_monitor #(
    parameter int W     = 8,
    parameter int CNT_W = 17,
    parameter int ACC_W = 34
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   win_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       x,
    input  logic [W-1:0]       y,
    input  logic [2*W-1:0]     z,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [ACC_W-1:0]   sum_abs_err,
    output logic [ACC_W-1:0]   sum_err,
    output logic [2*W-1:0]     max_abs_err,
    output logic [W-1:0]       max_x,
    output logic [W-1:0]       max_y
`ifdef ERR_MON_SQ_EN
    ,
    output logic [2*ACC_W-1:0] sum_sq_err
`endif
);
    localparam int STAGES = 2;
    localparam int PW     = 2 * W;
    localparam int DW     = PW + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    P_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] S_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] S_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [W-1:0]         x;
        logic [W-1:0]         y;
        logic signed [DW-1:0] d;
    } s1_t;

    typedef struct packed {
        logic [W-1:0]         x;
        logic [W-1:0]         y;
        logic signed [DW-1:0] d;
        logic [PW-1:0]        ad;
    } s2_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     win_len_q;
    logic [CNT_W-1:0]     acc_cnt;
    logic [STAGES-1:0]    vld_pipe;
    s1_t                  s1;
    s2_t                  s2;

    logic                 accept;
    logic                 start_ok;
    logic                 last_accept;
    logic [PW-1:0]        prod;
    logic signed [DW-1:0] d_in;
    logic [PW-1:0]        ad1;

    logic [ACC_W:0]       abs_sum_nxt;
    logic [ACC_W:0]       serr_nxt;
    logic                 serr_ovf;

    // d spans [-(2^PW-1), 2^PW-1], so its magnitude always fits in PW bits.
    assign prod        = PW'(x) * PW'(y);
    assign d_in        = $signed({1'b0, prod}) - $signed({1'b0, z});
    assign accept      = in_valid && in_ready;
    assign start_ok    = start && (state == IDLE || state == DONE);
    assign last_accept = accept && ((acc_cnt + CNT_ONE) == win_len_q);
    assign ad1         = s1.d[DW-1] ? ((~s1.d[PW-1:0]) + P_ONE) : s1.d[PW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (win_len == '0) ? DRAIN : RUN;
            RUN:        if (last_accept) state_nxt = DRAIN;
            DRAIN:      if (vld_pipe == '0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            RUN:     begin in_ready = 1'b1; busy = 1'b1; end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_len_q <= '0;
            acc_cnt   <= '0;
            vld_pipe  <= '0;
            s1        <= '0;
            s2        <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], accept};
            if (start_ok) begin
                win_len_q <= win_len;
                acc_cnt   <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + CNT_ONE;
            end
            if (accept) begin
                s1.x <= x;
                s1.y <= y;
                s1.d <= d_in;
            end
            if (vld_pipe[0]) begin
                s2.x  <= s1.x;
                s2.y  <= s1.y;
                s2.d  <= s1.d;
                s2.ad <= ad1;
            end
        end
    end

    assign abs_sum_nxt = {1'b0, sum_abs_err} + {{(ACC_W+1-PW){1'b0}}, s2.ad};
    assign serr_nxt    = {sum_err[ACC_W-1], sum_err} + {{(ACC_W+1-DW){s2.d[DW-1]}}, s2.d};
    assign serr_ovf    = serr_nxt[ACC_W] != serr_nxt[ACC_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            sum_err     <= '0;
            max_abs_err <= '0;
            max_x       <= '0;
            max_y       <= '0;
        end else if (start_ok) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            sum_err     <= '0;
            max_abs_err <= '0;
            max_x       <= '0;
            max_y       <= '0;
        end else if (vld_pipe[STAGES-1]) begin
            sample_cnt  <= sample_cnt + CNT_ONE;
            err_cnt     <= err_cnt + {{(CNT_W-1){1'b0}}, |s2.d};
            sum_abs_err <= abs_sum_nxt[ACC_W] ? '1 : abs_sum_nxt[ACC_W-1:0];
            if (serr_ovf) sum_err <= serr_nxt[ACC_W] ? S_MIN : S_MAX;
            else          sum_err <= serr_nxt[ACC_W-1:0];
            // Strict compare keeps the first sample of a tie.
            if (s2.ad > max_abs_err) begin
                max_abs_err <= s2.ad;
                max_x       <= s2.x;
                max_y       <= s2.y;
            end
        end
    end

`ifdef ERR_MON_SQ_EN
    localparam int SQW = 2 * DW;
    logic signed [SQW-1:0] sq;
    logic [2*ACC_W:0]      sq_sum_nxt;

    assign sq         = SQW'(s2.d) * SQW'(s2.d);
    assign sq_sum_nxt = {1'b0, sum_sq_err} + {{(2*ACC_W+1-SQW){1'b0}}, sq};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     sum_sq_err <= '0;
        else if (start_ok)           sum_sq_err <= '0;
        else if (vld_pipe[STAGES-1]) sum_sq_err <= sq_sum_nxt[2*ACC_W] ? '1 : sq_sum_nxt[2*ACC_W-1:0];
    end
`endif

endmodule

// File: doc/approx_mult_err_monitor.md
Name: approx_mult_err_monitor

Overview:
- Downstream evaluation stage for the 8x8 unsigned approximate multipliers; consumes operand pairs and the approximate product `z`.
- Recomputes the exact product internally.
- Accumulates error statistics over a programmable window: error count, sum of absolute error, signed error sum, and worst case with its operands.
- Results are held for readout once the window completes; used in hardware sweeps of multiplier variants.

Parameters:
- W, 8, operand width; product width is 2W.
- CNT_W, 17, width of window length and sample/error counters (allows an exhaustive 65536-sample sweep).
- ACC_W, 34, width of the error-sum accumulators.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle pulse; begins a new window.
- win_len  input  CNT_W  number of samples in the window; latched on accepted start.
- in_valid  input  1  x/y/z valid.
- in_ready  output  1  monitor accepts a sample this cycle.
- x  input  W  multiplier operand x.
- y  input  W  multiplier operand y.
- z  input  2W  approximate product for (x,y).
- busy  output  1  state is RUN or DRAIN.
- done  output  1  state is DONE; all result outputs are final.
- sample_cnt  output  CNT_W  samples accumulated.
- err_cnt  output  CNT_W  samples where z != x*y.
- sum_abs_err  output  ACC_W  sum of |x*y - z|.
- sum_err  output  ACC_W  signed (two's complement) sum of (x*y - z).
- max_abs_err  output  2W  largest |x*y - z|.
- max_x  output  W  x of the worst-case sample.
- max_y  output  W  y of the worst-case sample.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; pipeline valids are cleared.
  - All outputs are 0: in_ready, busy, done and every result register.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=0. start -> clear all result registers, latch win_len, go to RUN. If the latched win_len is 0, go straight to DRAIN.
  - RUN: in_ready=1 while accepted < win_len. A sample is accepted when in_valid && in_ready. On the accept that makes accepted == win_len, go to DRAIN; in_ready=0 from the next cycle.
  - DRAIN: in_ready=0. Wait until both pipeline stages are empty (at most 2 cycles), then go to DONE.
  - DONE: done=1; results are stable. start -> clear results, latch win_len, go to RUN (same rules as IDLE).
  - start in RUN or DRAIN is ignored.
- Pipeline, 2 stages:
  - S1 registers x, y, and the signed difference d = x*y - z (2W+1 bits, exact product computed at full 2W width).
  - S2 updates the accumulators.
  - Results reflect a sample 2 cycles after its accept.
- Accumulator updates per sample:
  - sample_cnt += 1.
  - err_cnt += (d != 0).
  - sum_abs_err += |d|.
  - sum_err += sign-extended d.
- Worst-case capture: if |d| > max_abs_err (strictly greater), update max_abs_err, max_x, max_y. Ties keep the first occurrence; an all-exact window leaves max_x = max_y = 0.
- Saturation:
  - sum_abs_err saturates at all-ones.
  - sum_err saturates at the signed max/min of ACC_W.
  - Counters cannot overflow because the window is at most 2^CNT_W - 1 samples.
- Gaps: in_valid low in RUN stalls without error; a window completes only on the win_len-th accept.
- Reset mid-RUN discards partial results; no done is produced.

Optional Feature:
- ERR_MON_SQ_EN: when defined, adds output sum_sq_err (2*ACC_W bits), the saturating sum of d*d, updated in S2 with the same timing as the other accumulators and cleared on start/reset.
- Without the macro the port and its multiplier are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> done=0, busy=0, in_ready=0, all results 0 immediately.
- Exact window: win_len=3; samples (2,3,6), (0,255,0), (255,255,65025) -> done; sample_cnt=3, err_cnt=0, sum_abs_err=0, sum_err=0, max_abs_err=0.
- Single error: win_len=1; (255,255,z=65000) -> err_cnt=1, sum_abs_err=25, sum_err=+25, max_abs_err=25, max_x=255, max_y=255; done 3 cycles after the accept (2 pipeline cycles + DONE transition).
- Mixed sign with gaps: win_len=2; (10,10,90), 3 idle cycles, (3,3,12); start pulsed in RUN -> start ignored; sum_abs_err=13, sum_err=+7, err_cnt=2, max_abs_err=10, max_x=10, max_y=10.
- Zero window and restart: start with win_len=0 -> DONE with all-zero results, no in_ready; then start with win_len=1, sample (1,1,0) -> results cleared and rebuilt: sum_err=+1, max_abs_err=1.
- ERR_MON_SQ_EN: mixed-sign scenario -> sum_sq_err=109; rst asserted during RUN -> busy=0, sum_sq_err=0.
